// File: rtl/fire_scheduler_pkg.sv
// Shared types and weapon profiles for the per-player fire scheduler.
// Profiles fix burst length, intra-burst gap, cooldown and reload length in frames.
package fire_scheduler_pkg;

   localparam int unsigned PROF_W  = 8;
   localparam int unsigned BURST_W = 2;
   localparam int unsigned AMMO_W  = 5;
   localparam int unsigned STATE_W = 3;

   typedef logic [STATE_W-1:0] fire_state_t;

   localparam fire_state_t ST_IDLE     = 3'd0;
   localparam fire_state_t ST_FIRE     = 3'd1;
   localparam fire_state_t ST_GAP      = 3'd2;
   localparam fire_state_t ST_COOLDOWN = 3'd3;
   localparam fire_state_t ST_RELOAD   = 3'd4;

   typedef struct packed {
      logic [BURST_W-1:0] burst;
      logic [PROF_W-1:0]  gap;
      logic [PROF_W-1:0]  cool;
      logic [PROF_W-1:0]  reload;
   } weapon_profile_t;

   localparam weapon_profile_t PROF_TRACER = '{
      burst:  2'd1,
      gap:    8'd0,
      cool:   8'd3,
      reload: 8'd69
   };

   localparam weapon_profile_t PROF_GENGI = '{
      burst:  2'd3,
      gap:    8'd2,
      cool:   8'd30,
      reload: 8'd100
   };

   // 00 is tracer; every other code selects the gengi profile
   function automatic weapon_profile_t get_profile(input logic [1:0] chara_id);
      weapon_profile_t prof;
      if (chara_id == 2'b00) begin
         prof = PROF_TRACER;
      end else begin
         prof = PROF_GENGI;
      end
      return prof;
   endfunction

endpackage

// File: rtl/fire_scheduler_if.sv
// Bus between keyboard decode / bullet pool and the fire scheduler.
// master drives requests and slot status, slave is the scheduler.
interface fire_scheduler_if
   import fire_scheduler_pkg::*;
#(
   parameter int unsigned N_SLOTS = 20
);

   logic [1:0]               chara_id;
   logic                     press_j;
   logic [N_SLOTS-1:0][1:0]  slot_state;
   logic [N_SLOTS-1:0]       shoot;
   logic [N_SLOTS-1:0]       slot_reset;
   logic [AMMO_W-1:0]        ammo_left;
   logic                     reloading;

   modport master (
      output chara_id,
      output press_j,
      output slot_state,
      input  shoot,
      input  slot_reset,
      input  ammo_left,
      input  reloading
   );

   modport slave (
      input  chara_id,
      input  press_j,
      input  slot_state,
      output shoot,
      output slot_reset,
      output ammo_left,
      output reloading
   );

endinterface

// File: rtl/fire_scheduler_picker.sv
// Combinational priority encoder: lowest-index bullet slot whose state is wait (00).
// found_c is low when every slot is busy; onehot_c is then all zeros.
module free_slot_picker #(
   parameter int unsigned N_SLOTS = 20
) (
   input  logic [N_SLOTS-1:0][1:0] slot_state,
   output logic                    found_c,
   output logic [N_SLOTS-1:0]      onehot_c
);

   localparam int unsigned IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

   logic [IDX_W-1:0] index_c;

   // Scan downwards so the last hit, which wins, is the lowest free index
   always_comb begin
      found_c = 1'b0;
      index_c = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (slot_state[i] == 2'b00) begin
            found_c = 1'b1;
            index_c = IDX_W'(i);
         end
      end
   end

   always_comb begin
      onehot_c = '0;
      if (found_c) begin
         onehot_c = N_SLOTS'(1) << index_c;
      end
   end

endmodule

// File: rtl/fire_scheduler.sv
// Per-player shot sequencer: turns press_j into one-hot launch pulses into the bullet pool,
// enforcing burst cadence, cooldown, magazine count and reload with a pool-wide slot reset.
module fire_scheduler
   import fire_scheduler_pkg::*;
#(
   parameter int unsigned N_SLOTS  = 20,
   parameter int unsigned MAG_SIZE = 20,
   parameter int unsigned TIMER_W  = 10
) (
   input  logic             frame_clk,
   input  logic             Reset_n,
   fire_scheduler_if.slave  bus
);

   localparam logic [AMMO_W-1:0]  AMMO_FULL = AMMO_W'(MAG_SIZE);
   localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

   fire_state_t            state_q, state_d;
   logic [TIMER_W-1:0]     timer_q, timer_d;
   logic [BURST_W-1:0]     burst_q, burst_d;
   logic [AMMO_W-1:0]      ammo_q, ammo_d;
   weapon_profile_t        profile_q, profile_d;
   logic [N_SLOTS-1:0]     shoot_q, shoot_d;
   logic [N_SLOTS-1:0]     slot_reset_q, slot_reset_d;
   logic                   reloading_q, reloading_d;
   logic                   press_q;

   weapon_profile_t        prof_c;
   logic [BURST_W-1:0]     burst_inc_c;
   logic [TIMER_W-1:0]     gap_ld_c;
   logic [TIMER_W-1:0]     cool_ld_c;
   logic [TIMER_W-1:0]     reload_ld_c;
   logic [TIMER_W-1:0]     timer_dec_c;
   logic                   pick_found_c;
   logic [N_SLOTS-1:0]     pick_onehot_c;

   free_slot_picker #(
      .N_SLOTS (N_SLOTS)
   ) u_picker (
      .slot_state (bus.slot_state),
      .found_c    (pick_found_c),
      .onehot_c   (pick_onehot_c)
   );

   // Timer preloads: a state lasting K cycles is entered with K-1 and leaves on zero
   always_comb begin
      prof_c      = (state_q == ST_IDLE) ? get_profile(bus.chara_id) : profile_q;
      burst_inc_c = burst_q + BURST_W'(1);
      gap_ld_c    = '0;
      cool_ld_c   = '0;
      reload_ld_c = '0;
      if (prof_c.gap != '0) begin
         gap_ld_c = TIMER_W'(prof_c.gap - PROF_W'(1));
      end
      // Cooldown is COOL-1 cycles so a held trigger repeats every COOL+1 frames
      if (prof_c.cool > PROF_W'(1)) begin
         cool_ld_c = TIMER_W'(prof_c.cool - PROF_W'(2));
      end
      if (prof_c.reload != '0) begin
         reload_ld_c = TIMER_W'(prof_c.reload - PROF_W'(1));
      end
      timer_dec_c = (timer_q != '0) ? (timer_q - TIMER_ONE) : '0;
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      burst_d      = burst_q;
      ammo_d       = ammo_q;
      profile_d    = profile_q;
      shoot_d      = '0;
      slot_reset_d = '0;

      case (state_q)
         ST_IDLE: begin
            profile_d = prof_c;
            burst_d   = '0;
            if (ammo_q == '0) begin
               state_d = ST_RELOAD;
               timer_d = reload_ld_c;
            end else if (press_q && pick_found_c) begin
               state_d = ST_FIRE;
            end
         end

         ST_FIRE: begin
            // No free slot: hold here and retry next frame without spending ammo
            if (pick_found_c) begin
               shoot_d = pick_onehot_c;
               ammo_d  = (ammo_q != '0) ? (ammo_q - AMMO_W'(1)) : '0;
               if (ammo_q <= AMMO_W'(1)) begin
                  state_d = ST_RELOAD;
                  timer_d = reload_ld_c;
                  burst_d = '0;
               end else if (burst_inc_c == prof_c.burst) begin
                  state_d = ST_COOLDOWN;
                  timer_d = cool_ld_c;
                  burst_d = '0;
               end else begin
                  burst_d = burst_inc_c;
                  if (prof_c.gap == '0) begin
                     state_d = ST_FIRE;
                  end else begin
                     state_d = ST_GAP;
                     timer_d = gap_ld_c;
                  end
               end
            end
         end

         ST_GAP: begin
            if (timer_q == '0) begin
               state_d = ST_FIRE;
            end else begin
               timer_d = timer_dec_c;
            end
         end

         ST_COOLDOWN: begin
            if (timer_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_dec_c;
            end
         end

         ST_RELOAD: begin
            if (timer_q == '0) begin
               state_d      = ST_IDLE;
               slot_reset_d = '1;
               ammo_d       = AMMO_FULL;
            end else begin
               timer_d = timer_dec_c;
            end
         end

         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
            burst_d = '0;
         end
      endcase

      reloading_d = (state_d == ST_RELOAD);
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         burst_q      <= '0;
         ammo_q       <= AMMO_FULL;
         profile_q    <= PROF_TRACER;
         shoot_q      <= '0;
         slot_reset_q <= '0;
         reloading_q  <= 1'b0;
         press_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         burst_q      <= burst_d;
         ammo_q       <= ammo_d;
         profile_q    <= profile_d;
         shoot_q      <= shoot_d;
         slot_reset_q <= slot_reset_d;
         reloading_q  <= reloading_d;
         press_q      <= bus.press_j;
      end
   end

   assign bus.shoot      = shoot_q;
   assign bus.slot_reset = slot_reset_q;
   assign bus.ammo_left  = ammo_q;
   assign bus.reloading  = reloading_q;

endmodule

// File: tb/tb_fire_scheduler.sv
// Directed bench for fire_scheduler: cycle table for a single tracer shot, then hand sequences
// for held fire, gengi bursts, reload, slot stall, profile latching and async reset.
module tb_fire_scheduler;
   import fire_scheduler_pkg::*;

   localparam int unsigned N = 20;

   logic frame_clk = 1'b0;
   logic Reset_n;
   always #5 frame_clk = ~frame_clk;

   fire_scheduler_if #(.N_SLOTS(N)) bus ();

   fire_scheduler #(
      .N_SLOTS  (N),
      .MAG_SIZE (20),
      .TIMER_W  (10)
   ) dut (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .bus       (bus)
   );

   typedef struct {
      logic         press;
      logic [N-1:0] shoot;
      logic [4:0]   ammo;
      logic         reloading;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int shot_ofs[$];
   int shot_idx[$];
   int rel_cnt, rel_first, rst_cnt, rst_ofs;
   vec_t t1[8];
   int t3_ofs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // One frame: sample after the edge, then let the bullet-pool model react
   task automatic step();
      logic [N-1:0][1:0] st;
      @(posedge frame_clk);
      #1;
      st = bus.slot_state;
      if (bus.shoot != '0) begin
         check("shoot_onehot", 32'($countones(bus.shoot)), 32'd1);
         for (int i = 0; i < N; i++) begin
            if (bus.shoot[i]) st[i] = 2'b01;
         end
      end
      if (bus.slot_reset != '0) begin
         check("slot_reset_vs_shoot", 32'(bus.shoot), 32'd0);
         check("slot_reset_all", 32'(bus.slot_reset), 32'(20'hFFFFF));
         st = '0;
      end
      bus.slot_state = st;
   endtask

   task automatic run_window(input int n, input int press_n);
      shot_ofs.delete();
      shot_idx.delete();
      rel_cnt = 0; rel_first = -1; rst_cnt = 0; rst_ofs = -1;
      for (int i = 0; i < n; i++) begin
         bus.press_j = (i < press_n);
         step();
         if (bus.shoot != '0) begin
            shot_ofs.push_back(i);
            shot_idx.push_back(idx_of(bus.shoot));
         end
         if (bus.reloading) begin
            if (rel_first < 0) rel_first = i;
            rel_cnt++;
         end
         if (bus.slot_reset != '0) begin
            rst_cnt++;
            rst_ofs = i;
         end
      end
      bus.press_j = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_shoot"},      32'(bus.shoot),      32'd0);
      check({tag, "_slot_reset"}, 32'(bus.slot_reset), 32'd0);
      check({tag, "_ammo"},       32'(bus.ammo_left),  32'd20);
      check({tag, "_reloading"},  32'(bus.reloading),  32'd0);
   endtask

   initial begin
      Reset_n        = 1'b0;
      bus.press_j    = 1'b0;
      bus.chara_id   = 2'b00;
      bus.slot_state = '0;

      t1[0] = '{1'b1, 20'h00000, 5'd20, 1'b0};
      t1[1] = '{1'b0, 20'h00000, 5'd20, 1'b0};
      t1[2] = '{1'b0, 20'h00001, 5'd19, 1'b0};
      t1[3] = '{1'b0, 20'h00000, 5'd19, 1'b0};
      t1[4] = '{1'b0, 20'h00000, 5'd19, 1'b0};
      t1[5] = '{1'b0, 20'h00000, 5'd19, 1'b0};
      t1[6] = '{1'b0, 20'h00000, 5'd19, 1'b0};
      t1[7] = '{1'b0, 20'h00000, 5'd19, 1'b0};
      t3_ofs = '{2, 5, 8, 39, 42, 45};

      #12;
      check_reset_values("reset");
      Reset_n = 1'b1;

      // T1: single tracer pulse
      for (int i = 0; i < 8; i++) begin
         bus.press_j = t1[i].press;
         step();
         check($sformatf("t1_shoot[%0d]", i), 32'(bus.shoot), 32'(t1[i].shoot));
         check($sformatf("t1_ammo[%0d]", i),  32'(bus.ammo_left), 32'(t1[i].ammo));
         check($sformatf("t1_rel[%0d]", i),   32'(bus.reloading), 32'(t1[i].reloading));
      end
      bus.press_j = 1'b0;

      // T2: tracer held 40 frames -> period 4, slots 1..10
      run_window(48, 40);
      check("t2_count", 32'(shot_ofs.size()), 32'd10);
      for (int m = 0; m < shot_ofs.size() && m < 10; m++) begin
         check($sformatf("t2_ofs[%0d]", m), 32'(shot_ofs[m]), 32'(2 + 4 * m));
         check($sformatf("t2_idx[%0d]", m), 32'(shot_idx[m]), 32'(1 + m));
      end
      check("t2_ammo", 32'(bus.ammo_left), 32'd9);

      // T3: gengi held; bursts of 3 at GAP=2, 31-frame burst-to-burst spacing
      bus.chara_id = 2'b01;
      run_window(80, 39);
      check("t3_count", 32'(shot_ofs.size()), 32'd6);
      for (int m = 0; m < shot_ofs.size() && m < 6; m++) begin
         check($sformatf("t3_ofs[%0d]", m), 32'(shot_ofs[m]), 32'(t3_ofs[m]));
         check($sformatf("t3_idx[%0d]", m), 32'(shot_idx[m]), 32'(11 + m));
      end
      check("t3_ammo", 32'(bus.ammo_left), 32'd3);

      // T4: bring ammo to 1 with tracer, then a gengi burst truncates into reload
      bus.chara_id = 2'b00;
      run_window(8, 1);
      run_window(8, 1);
      check("t4_pre_ammo", 32'(bus.ammo_left), 32'd1);
      bus.chara_id = 2'b01;
      run_window(110, 1);
      check("t4_count", 32'(shot_ofs.size()), 32'd1);
      if (shot_idx.size() > 0) check("t4_idx", 32'(shot_idx[0]), 32'd19);
      check("t4_rel_first", 32'(rel_first), 32'd2);
      check("t4_rel_cnt", 32'(rel_cnt), 32'd100);
      check("t4_rst_cnt", 32'(rst_cnt), 32'd1);
      check("t4_rst_ofs", 32'(rst_ofs), 32'd102);
      check("t4_ammo", 32'(bus.ammo_left), 32'd20);
      check("t4_rel_end", 32'(bus.reloading), 32'd0);

      // T5: every slot in cooldown after entering FIRE -> stall until slot 7 frees
      bus.chara_id = 2'b00;
      bus.press_j = 1'b1;
      step();
      bus.press_j = 1'b0;
      step();
      bus.slot_state = {N{2'b11}};
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("t5_stall_shoot[%0d]", i), 32'(bus.shoot), 32'd0);
         check($sformatf("t5_stall_ammo[%0d]", i), 32'(bus.ammo_left), 32'd20);
      end
      bus.slot_state[7] = 2'b00;
      step();
      check("t5_shoot7", 32'(bus.shoot), 32'h80);
      check("t5_ammo", 32'(bus.ammo_left), 32'd19);
      bus.slot_state = '0;
      for (int i = 0; i < 4; i++) step();

      // T6a: chara_id changed after the first gengi shot must not cut the burst
      bus.chara_id = 2'b01;
      bus.press_j = 1'b1;
      step();
      bus.press_j = 1'b0;
      step();
      step();
      check("t6a_first", 32'(bus.shoot), 32'h1);
      bus.chara_id = 2'b00;
      run_window(12, 0);
      check("t6a_count", 32'(shot_ofs.size()), 32'd2);
      for (int m = 0; m < shot_ofs.size() && m < 2; m++) begin
         check($sformatf("t6a_ofs[%0d]", m), 32'(shot_ofs[m]), 32'(2 + 3 * m));
      end
      check("t6a_ammo", 32'(bus.ammo_left), 32'd16);
      for (int i = 0; i < 30; i++) step();

      // T6b: async reset right after the first burst shot
      bus.chara_id = 2'b01;
      bus.press_j = 1'b1;
      step();
      bus.press_j = 1'b0;
      step();
      step();
      check("t6b_first", 32'(bus.shoot), 32'h8);
      #2 Reset_n = 1'b0;
      #1 check_reset_values("t6b_async");
      #1 Reset_n = 1'b1;
      bus.chara_id = 2'b00;
      bus.slot_state = '0;
      run_window(8, 0);
      check("t6b_no_resume", 32'(shot_ofs.size()), 32'd0);

      // T6c: empty the magazine with tracer, then reset during reload
      run_window(90, 90);
      check("t6c_count", 32'(shot_ofs.size()), 32'd20);
      if (shot_ofs.size() == 20) begin
         check("t6c_last_ofs", 32'(shot_ofs[19]), 32'd78);
         check("t6c_last_idx", 32'(shot_idx[19]), 32'd19);
      end
      check("t6c_ammo", 32'(bus.ammo_left), 32'd0);
      check("t6c_reloading", 32'(bus.reloading), 32'd1);
      #2 Reset_n = 1'b0;
      #1 check_reset_values("t6c_async");
      #1 Reset_n = 1'b1;
      run_window(120, 0);
      check("t6c_no_slot_reset", 32'(rst_cnt), 32'd0);
      check("t6c_no_reload", 32'(rel_cnt), 32'd0);
      check("t6c_no_shot", 32'(shot_ofs.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
